// File: rtl/ma_stage_if.sv
// Data-memory port of the MA stage: ma_stage drives the request side (master),
// the data memory answers with read data and a load-complete strobe (slave).
interface ma_stage_if #(
  parameter int N = 7
);
  logic         dm_ena;
  logic         dm_wea;
  logic [N-1:0] dm_addra;
  logic [31:0]  dm_dina;
  logic [31:0]  dm_douta;
  logic         dm_done;

  modport master (
    output dm_ena, dm_wea, dm_addra, dm_dina,
    input  dm_douta, dm_done
  );

  modport slave (
    input  dm_ena, dm_wea, dm_addra, dm_dina,
    output dm_douta, dm_done
  );
endinterface

// File: rtl/ma_stage.sv
// Memory-access stage: issues data-memory requests, stalls while a load is
// outstanding, and registers the MA/RW bundle plus saturating ld/st counters.
module ma_stage #(
  parameter int N = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              is_ld_in,
  input  logic              is_st_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       op2_in,
  input  logic [3:0]        rd_in,
  input  logic              is_wb_in,
  input  logic [31:0]       pc_in,
  output logic              ma_stall,
  ma_stage_if.master        dm,
  output logic              rw_valid,
  output logic [31:0]       rw_ld_data,
  output logic [31:0]       rw_alu,
  output logic [3:0]        rw_rd,
  output logic              rw_is_wb,
  output logic              rw_is_ld,
  output logic              rw_fault,
  output logic [31:0]       rw_pc,
  output logic [15:0]       ld_count,
  output logic [15:0]       st_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;

  logic oob;
  logic ld_go;
  logic st_go;
  logic ld_done;
  logic fault_nxt;

  assign oob       = |alu_in[31:N];
  assign ld_go     = valid_in & is_ld_in & ~oob;
  assign st_go     = valid_in & is_st_in & ~oob;
  assign ld_done   = (state == WAIT) & dm.dm_done;
  assign fault_nxt = valid_in & (is_ld_in | is_st_in) & oob;

  assign dm.dm_addra = alu_in[N-1:0];
  assign dm.dm_dina  = op2_in;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // No timeout on WAIT: the memory is trusted to eventually raise dm_done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_go) state_nxt = WAIT;
      WAIT:    if (dm.dm_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dm.dm_ena = 1'b0;
    dm.dm_wea = 1'b0;
    ma_stall  = 1'b0;
    case (state)
      IDLE: begin
        dm.dm_ena = ld_go | st_go;
        dm.dm_wea = st_go;
        ma_stall  = ld_go;
      end
      WAIT:    ma_stall = ~dm.dm_done;
      default: ma_stall = 1'b0;
    endcase
  end

  // While stalled only rw_valid moves (to a bubble); the payload fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_valid   <= 1'b0;
      rw_ld_data <= 32'd0;
      rw_alu     <= 32'd0;
      rw_rd      <= 4'd0;
      rw_is_wb   <= 1'b0;
      rw_is_ld   <= 1'b0;
      rw_fault   <= 1'b0;
      rw_pc      <= 32'd0;
    end else if (!ma_stall) begin
      rw_valid   <= valid_in;
      rw_ld_data <= ld_done ? dm.dm_douta : 32'd0;
      rw_alu     <= alu_in;
      rw_rd      <= rd_in;
      rw_is_wb   <= is_wb_in & ~fault_nxt;
      rw_is_ld   <= is_ld_in;
      rw_fault   <= fault_nxt;
      rw_pc      <= pc_in;
    end else begin
      rw_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count <= 16'd0;
      st_count <= 16'd0;
    end else begin
      if (ld_done && ld_count != 16'hFFFF)
        ld_count <= ld_count + 16'd1;
      if (state == IDLE && st_go && st_count != 16'hFFFF)
        st_count <= st_count + 16'd1;
    end
  end

endmodule
